word_ingress: RTL

Parametrised byte-to-word assembler for the housekeeper receive path. It sits between the UART byte receiver and the command decoder. It packs a stream of accepted bytes into words of `BYTES_PER_WORD` bytes in a configurable byte order, with flush support for partial words. Completed words are buffered in a FIFO and presented on a ready/valid output; byte-side backpressure is signalled through `Rdyn`, and dropped bytes are flagged.

---
 rtl/word_ingress_if.sv | 27 ++
 rtl/word_ingress.sv | 108 ++++++++++
 2 files changed

// File: rtl/word_ingress_if.sv
// Byte-in / word-out handshake bundle for word_ingress.
// The master side feeds bytes and accepts words; the slave side is the assembler.
interface word_ingress_if #(
  parameter int BYTES_PER_WORD = 4
) ();
  localparam int BW = $clog2(BYTES_PER_WORD + 1);

  logic [7:0]                  Data;
  logic                        DataValid;
  logic                        Flush;
  logic                        Rdyn;
  logic [8*BYTES_PER_WORD-1:0] WordData;
  logic [BW-1:0]               WordBytes;
  logic                        WordValid;
  logic                        WordReady;
  logic                        Overrun;

  modport master (
    output Data, DataValid, Flush, WordReady,
    input  Rdyn, WordData, WordBytes, WordValid, Overrun
  );

  modport slave (
    input  Data, DataValid, Flush, WordReady,
    output Rdyn, WordData, WordBytes, WordValid, Overrun
  );
endinterface

// File: rtl/word_ingress.sv
// Byte-to-word assembler: packs accepted bytes into words, flushes partial words,
// and buffers completed words in a first-word-fall-through FIFO.
module word_ingress #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int BIG_ENDIAN     = 0
) (
  input  logic          Clk,
  input  logic          ARstn,
  word_ingress_if.slave bus
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int BW = $clog2(BYTES_PER_WORD + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = 8 * BYTES_PER_WORD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] asm_q, asm_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [WW-1:0] mem_d [FIFO_DEPTH];
  logic [BW-1:0] nb_q [FIFO_DEPTH];
  logic [BW-1:0] nb_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic          rdyn_q, rdyn_d;
  logic          overrun_q, overrun_d;

  logic          accept;
  logic          flush_ok;
  logic          complete;
  logic          push;
  logic          pop;
  logic [WW-1:0] push_word;
  logic [BW-1:0] push_bytes;

  // The incoming byte is merged before the flush decision, so a same-cycle
  // byte+flush emits a word containing that byte.
  always_comb begin
    accept     = bus.DataValid & ~rdyn_q;
    flush_ok   = bus.Flush & ~rdyn_q;
    complete   = accept & (cnt_q == CW'(BYTES_PER_WORD - 1));
    push_bytes = BW'(cnt_q) + BW'(accept);
    push_word  = asm_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (accept && (cnt_q == CW'(k))) begin
        if (BIG_ENDIAN != 0) begin
          push_word[8*(BYTES_PER_WORD-1-k) +: 8] = bus.Data;
        end else begin
          push_word[8*k +: 8] = bus.Data;
        end
      end
    end
    push = complete | (flush_ok & (push_bytes != '0));
    pop  = (occ_q != '0) & bus.WordReady;
  end

  always_comb begin
    cnt_d     = push ? '0 : cnt_q + CW'(accept);
    asm_d     = push ? '0 : push_word;
    mem_d     = mem_q;
    nb_d      = nb_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      nb_d[wr_ptr_q]  = push_bytes;
    end
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    occ_d     = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    rdyn_d    = (occ_d == (PW+1)'(FIFO_DEPTH));
    overrun_d = overrun_q | (bus.DataValid & rdyn_q);
  end

  // Storage is cleared on reset so the head word reads as zero while empty after reset.
  always_ff @(posedge Clk or negedge ARstn) begin
    if (!ARstn) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
        nb_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rdyn_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        nb_q[i]  <= nb_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      rdyn_q    <= rdyn_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.Rdyn      = rdyn_q;
  assign bus.WordData  = mem_q[rd_ptr_q];
  assign bus.WordBytes = nb_q[rd_ptr_q];
  assign bus.WordValid = (occ_q != '0);
  assign bus.Overrun   = overrun_q;
endmodule
